// File: rtl/sp_ram_param.sv
// sp_ram_param
// Parametrised single-port word RAM with byte-lane write enables, a
// selectable read latency and a hardware clear sequencer. After every reset
// the array is filled with INIT_VALUE, one word per cycle. After that the
// RAM serves one request per cycle.
//
// Parameters
//   WIDTH        data word width (multiple of 8)
//   DEPTH        number of words (>= 2, need not be a power of two)
//   ADDR_W       address width
//   READ_LATENCY 0 = combinational read, 1 = registered read
//   INIT_VALUE   value written to every word by the clear sequencer
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req, we      request valid / write(1) or read(0)
//   addr         word address
//   be           byte-lane write enables (bit i covers wdata[8i+7:8i])
//   wdata        write data
//   rdata        read data
//   rvalid       rdata carries the result of an accepted read
//   ready        clear finished, requests are accepted
//   oob          accepted request addressed a word >= DEPTH
module sp_ram_param #(
    parameter int                 WIDTH        = 32,
    parameter int                 DEPTH        = 16,
    parameter int                 ADDR_W       = $clog2(DEPTH),
    parameter int                 READ_LATENCY = 1,
    parameter logic [WIDTH-1:0]   INIT_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WIDTH/8-1:0]    be,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  ready,
    output logic                  oob
);

    localparam int                NB      = WIDTH / 8;
    // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic [ADDR_W-1:0]   clr_cnt_s;
    logic                ready_r;
    logic [WIDTH-1:0]    mem_r [DEPTH];

    logic                in_range_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic                wr_oob_s;
    logic                rd_oob_s;
    logic [WIDTH-1:0]    rd_word_s;

    // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NB-1:0]    lane_en
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Next-state logic: walk the clear counter through every word, then run.
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_C) begin
                    state_s   = ST_RUN;
                    clr_cnt_s = '0;
                end else begin
                    state_s   = ST_CLEAR;
                    clr_cnt_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_s   = ST_RUN;
                clr_cnt_s = '0;
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_cnt_s = '0;
            end
        endcase
    end

    // State, clear counter and ready flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
            ready_r   <= (state_s == ST_RUN);
        end
    end

    // Request decode; requests are only honoured once the clear has finished.
    always_comb begin
        in_range_s = ({1'b0, addr} < DEPTH_C);
        wr_acc_s   = req & we & ready_r;
        rd_acc_s   = req & ~we & ready_r;
        // A write with no lanes enabled does nothing, so it is not flagged either.
        wr_oob_s   = wr_acc_s & ~in_range_s & (|be);
        rd_oob_s   = rd_acc_s & ~in_range_s;
        if (in_range_s) begin
            rd_word_s = mem_r[addr];
        end else begin
            rd_word_s = '0;
        end
    end

    // Storage array: clear writes during CLEAR, byte-lane writes during RUN.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= INIT_VALUE;
        end else if (wr_acc_s && in_range_s) begin
            mem_r[addr] <= merge_lanes(mem_r[addr], wdata, be);
        end
    end

    generate
        if (READ_LATENCY != 0) begin : g_reg_read
            logic [WIDTH-1:0] rdata_r;
            logic             rvalid_r;
            logic             oob_r;

            // Registered read port; rdata keeps its last value between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_r  <= '0;
                    rvalid_r <= 1'b0;
                    oob_r    <= 1'b0;
                end else begin
                    rvalid_r <= rd_acc_s;
                    oob_r    <= rd_oob_s | wr_oob_s;
                    if (rd_acc_s) begin
                        rdata_r <= rd_word_s;
                    end
                end
            end

            assign rdata  = rdata_r;
            assign rvalid = rvalid_r;
            assign oob    = oob_r;
        end else begin : g_comb_read
            logic oob_wr_r;

            // Write out-of-range flag stays registered even with a combinational read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    oob_wr_r <= 1'b0;
                end else begin
                    oob_wr_r <= wr_oob_s;
                end
            end

            assign rdata  = rd_word_s;
            assign rvalid = rd_acc_s;
            assign oob    = rd_oob_s | oob_wr_r;
        end
    endgenerate

    assign ready = ready_r;

endmodule
